// File: rtl/alu_rs.sv
// Integer ALU reservation station.
// Buffers issued ALU ops and resolves operand tags by snooping two CDBs.
// Each cycle it sends the lowest-index ready op to the ALU through registered outputs.
module alu_rs #(
    parameter int unsigned RS_DEPTH = 8,
    parameter int unsigned IDX_W    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rob_rst,
    input  logic        hci_rdy,
    input  logic        alu_in_en,
    input  logic [4:0]  alu_op_type,
    input  logic [4:0]  vdest_id,
    input  logic        op1_dependent,
    input  logic [31:0] op1,
    input  logic        op2_dependent,
    input  logic [31:0] op2,
    input  logic        cdb0_valid,
    input  logic [4:0]  cdb0_id,
    input  logic [31:0] cdb0_val,
    input  logic        cdb1_valid,
    input  logic [4:0]  cdb1_id,
    input  logic [31:0] cdb1_val,
    output logic        rs_full,
    output logic        exec_en,
    output logic [4:0]  exec_op,
    output logic [31:0] exec_a,
    output logic [31:0] exec_b,
    output logic [4:0]  exec_dest
);

    // One slot is kept back for the op already latched in the decoder stage.
    localparam logic [IDX_W:0] FullThr = (IDX_W + 1)'(RS_DEPTH - 1);

    // Entry storage; while qN is set, vN[4:0] holds the producer's ROB tag.
    logic [RS_DEPTH-1:0] busy_q, busy_d;
    logic [RS_DEPTH-1:0] q1_q, q1_d;
    logic [RS_DEPTH-1:0] q2_q, q2_d;
    logic [4:0]          op_q   [RS_DEPTH];
    logic [4:0]          op_d   [RS_DEPTH];
    logic [4:0]          dest_q [RS_DEPTH];
    logic [4:0]          dest_d [RS_DEPTH];
    logic [31:0]         v1_q   [RS_DEPTH];
    logic [31:0]         v1_d   [RS_DEPTH];
    logic [31:0]         v2_q   [RS_DEPTH];
    logic [31:0]         v2_d   [RS_DEPTH];

    logic        exec_en_q;
    logic [4:0]  exec_op_q;
    logic [31:0] exec_a_q;
    logic [31:0] exec_b_q;
    logic [4:0]  exec_dest_q;

    logic [RS_DEPTH-1:0] ready_vec;
    logic [IDX_W:0]      busy_cnt;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic                do_alloc;
    logic                do_dispatch;

    // Returns {pending, value} after checking a pending tag against both CDBs; cdb0 wins.
    function automatic logic [32:0] resolve(input logic pend, input logic [31:0] val);
        logic [32:0] r;
        r = {pend, val};
        if (pend) begin
            if (cdb0_valid && (cdb0_id == val[4:0])) begin
                r = {1'b0, cdb0_val};
            end else if (cdb1_valid && (cdb1_id == val[4:0])) begin
                r = {1'b0, cdb1_val};
            end
        end
        return r;
    endfunction

    // Occupancy count, lowest free slot and lowest ready slot from start-of-cycle state.
    always_comb begin
        ready_vec  = busy_q & ~q1_q & ~q2_q;
        busy_cnt   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            busy_cnt = busy_cnt + {{IDX_W{1'b0}}, busy_q[i]};
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ready_vec[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
        rs_full     = (busy_cnt >= FullThr);
        do_dispatch = hci_rdy && !rob_rst && sel_found;
        // An issue with no free slot is dropped outright.
        do_alloc    = alu_in_en && hci_rdy && !rob_rst && free_found;
    end

    // Next entry state: wakeup, dispatch release, allocation with bypass, then flush.
    always_comb begin
        busy_d = busy_q;
        q1_d   = q1_q;
        q2_d   = q2_q;
        op_d   = op_q;
        dest_d = dest_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        // Wakeup runs even while stalled so no broadcast is missed.
        for (int i = 0; i < int'(RS_DEPTH); i++) begin
            if (busy_q[i]) begin
                {q1_d[i], v1_d[i]} = resolve(q1_q[i], v1_q[i]);
                {q2_d[i], v2_d[i]} = resolve(q2_q[i], v2_q[i]);
            end
        end
        if (do_dispatch) begin
            busy_d[sel_idx] = 1'b0;
        end
        // free_idx is never sel_idx, so a slot released this cycle is not reused yet.
        if (do_alloc) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = alu_op_type;
            dest_d[free_idx] = vdest_id;
            {q1_d[free_idx], v1_d[free_idx]} = resolve(op1_dependent, op1);
            {q2_d[free_idx], v2_d[free_idx]} = resolve(op2_dependent, op2);
        end
        if (rob_rst) begin
            busy_d = '0;
        end
    end

    // Entry state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            q1_q   <= '0;
            q2_q   <= '0;
            for (int i = 0; i < int'(RS_DEPTH); i++) begin
                op_q[i]   <= '0;
                dest_q[i] <= '0;
                v1_q[i]   <= '0;
                v2_q[i]   <= '0;
            end
        end else begin
            busy_q <= busy_d;
            q1_q   <= q1_d;
            q2_q   <= q2_d;
            op_q   <= op_d;
            dest_q <= dest_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
        end
    end

    // Registered dispatch port; payload holds its last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_en_q   <= 1'b0;
            exec_op_q   <= '0;
            exec_a_q    <= '0;
            exec_b_q    <= '0;
            exec_dest_q <= '0;
        end else begin
            exec_en_q <= do_dispatch;
            if (do_dispatch) begin
                exec_op_q   <= op_q[sel_idx];
                exec_a_q    <= v1_q[sel_idx];
                exec_b_q    <= v2_q[sel_idx];
                exec_dest_q <= dest_q[sel_idx];
            end
        end
    end

    assign exec_en   = exec_en_q;
    assign exec_op   = exec_op_q;
    assign exec_a    = exec_a_q;
    assign exec_b    = exec_b_q;
    assign exec_dest = exec_dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: a per-cycle behavioural model plus directed literal checks.
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rob_rst;
    logic        hci_rdy;
    logic        alu_in_en;
    logic [4:0]  alu_op_type;
    logic [4:0]  vdest_id;
    logic        op1_dependent;
    logic [31:0] op1;
    logic        op2_dependent;
    logic [31:0] op2;
    logic        cdb0_valid;
    logic [4:0]  cdb0_id;
    logic [31:0] cdb0_val;
    logic        cdb1_valid;
    logic [4:0]  cdb1_id;
    logic [31:0] cdb1_val;
    logic        rs_full;
    logic        exec_en;
    logic [4:0]  exec_op;
    logic [31:0] exec_a;
    logic [31:0] exec_b;
    logic [4:0]  exec_dest;

    int checks = 0;
    int errors = 0;

    alu_rs #(.RS_DEPTH(8), .IDX_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rob_rst      (rob_rst),
        .hci_rdy      (hci_rdy),
        .alu_in_en    (alu_in_en),
        .alu_op_type  (alu_op_type),
        .vdest_id     (vdest_id),
        .op1_dependent(op1_dependent),
        .op1          (op1),
        .op2_dependent(op2_dependent),
        .op2          (op2),
        .cdb0_valid   (cdb0_valid),
        .cdb0_id      (cdb0_id),
        .cdb0_val     (cdb0_val),
        .cdb1_valid   (cdb1_valid),
        .cdb1_id      (cdb1_id),
        .cdb1_val     (cdb1_val),
        .rs_full      (rs_full),
        .exec_en      (exec_en),
        .exec_op      (exec_op),
        .exec_a       (exec_a),
        .exec_b       (exec_b),
        .exec_dest    (exec_dest)
    );

    always #5 clk = ~clk;

    // Behavioural model: waiting operands keep their tag separately from their value.
    typedef struct {
        bit          busy;
        bit          rdy1;
        bit          rdy2;
        logic [4:0]  op;
        logic [4:0]  dest;
        logic [4:0]  t1;
        logic [4:0]  t2;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t        m [8];
    bit          m_en;
    logic [4:0]  m_op;
    logic [4:0]  m_dest;
    logic [31:0] m_a;
    logic [31:0] m_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bus_hit(input logic [4:0] tag, output logic [31:0] val);
        val = '0;
        if (cdb0_valid && cdb0_id == tag) begin
            val = cdb0_val;
            return 1'b1;
        end
        if (cdb1_valid && cdb1_id == tag) begin
            val = cdb1_val;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
        m_en = 1'b0; m_op = '0; m_dest = '0; m_a = '0; m_b = '0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        ent_t        old [8];
        int          cand;
        int          free;
        logic [31:0] v;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (rob_rst) begin
            for (int i = 0; i < 8; i++) m[i].busy = 1'b0;
            m_en = 1'b0;
            return;
        end
        old  = m;
        cand = -1;
        free = -1;
        for (int i = 0; i < 8; i++) begin
            if (hci_rdy && cand < 0 && old[i].busy && old[i].rdy1 && old[i].rdy2) cand = i;
            if (free < 0 && !old[i].busy) free = i;
        end
        for (int i = 0; i < 8; i++) begin
            if (m[i].busy && !m[i].rdy1 && bus_hit(m[i].t1, v)) begin
                m[i].rdy1 = 1'b1; m[i].a = v;
            end
            if (m[i].busy && !m[i].rdy2 && bus_hit(m[i].t2, v)) begin
                m[i].rdy2 = 1'b1; m[i].b = v;
            end
        end
        if (cand >= 0) begin
            m_en = 1'b1; m_op = old[cand].op; m_dest = old[cand].dest;
            m_a = old[cand].a; m_b = old[cand].b;
            m[cand].busy = 1'b0;
        end else begin
            m_en = 1'b0;
        end
        if (alu_in_en && hci_rdy && free >= 0) begin
            m[free].busy = 1'b1;
            m[free].op   = alu_op_type;
            m[free].dest = vdest_id;
            m[free].t1   = op1[4:0];
            m[free].t2   = op2[4:0];
            m[free].rdy1 = !op1_dependent;
            m[free].rdy2 = !op2_dependent;
            m[free].a    = op1;
            m[free].b    = op2;
            if (op1_dependent && bus_hit(op1[4:0], v)) begin
                m[free].rdy1 = 1'b1; m[free].a = v;
            end
            if (op2_dependent && bus_hit(op2[4:0], v)) begin
                m[free].rdy2 = 1'b1; m[free].b = v;
            end
        end
    endtask

    function automatic bit model_full();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m[i].busy) n++;
        return n >= 7;
    endfunction

    // Compare every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("exec_en", {31'd0, exec_en}, {31'd0, m_en});
            chk("exec_op", {27'd0, exec_op}, {27'd0, m_op});
            chk("exec_a", exec_a, m_a);
            chk("exec_b", exec_b, m_b);
            chk("exec_dest", {27'd0, exec_dest}, {27'd0, m_dest});
            chk("rs_full", {31'd0, rs_full}, {31'd0, model_full()});
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        alu_in_en = 1'b0; op1_dependent = 1'b0; op2_dependent = 1'b0;
        cdb0_valid = 1'b0; cdb1_valid = 1'b0; rob_rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [4:0] dest,
                         input bit d1, input logic [31:0] o1,
                         input bit d2, input logic [31:0] o2);
        alu_in_en = 1'b1; alu_op_type = op; vdest_id = dest;
        op1_dependent = d1; op1 = o1; op2_dependent = d2; op2 = o2;
    endtask

    task automatic lit(input string name, input bit en, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] dest);
        chk({name, "_en"}, {31'd0, exec_en}, {31'd0, en});
        if (en) begin
            chk({name, "_a"}, exec_a, a);
            chk({name, "_b"}, exec_b, b);
            chk({name, "_dest"}, {27'd0, exec_dest}, {27'd0, dest});
        end
    endtask

    initial begin
        rst_n = 1'b0; hci_rdy = 1'b1; alu_op_type = '0; vdest_id = '0;
        op1 = '0; op2 = '0; cdb0_id = '0; cdb0_val = '0; cdb1_id = '0; cdb1_val = '0;
        idle();
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_exec_en", {31'd0, exec_en}, 32'd0);
        chk("rst_exec_a", exec_a, 32'd0);
        chk("rst_rs_full", {31'd0, rs_full}, 32'd0);

        // Ready op: exec two edges after issue.
        issue(5'h00, 5'd3, 1'b0, 32'd7, 1'b0, 32'd9);
        tick(); idle();
        lit("lat_e1", 1'b0, 0, 0, 0);
        tick();
        lit("lat_e2", 1'b1, 32'd7, 32'd9, 5'd3);
        repeat (3) begin
            tick();
            lit("lat_after", 1'b0, 0, 0, 0);
        end

        // Wakeup through cdb1, then cdb0.
        for (int c = 0; c < 2; c++) begin
            issue(5'h01, 5'd6, 1'b1, 32'd12, 1'b0, 32'd5);
            tick(); idle();
            repeat (3) begin
                tick();
                lit("wk_wait", 1'b0, 0, 0, 0);
            end
            if (c == 0) begin
                cdb1_valid = 1'b1; cdb1_id = 5'd12; cdb1_val = 32'hDEADBEEF;
            end else begin
                cdb0_valid = 1'b1; cdb0_id = 5'd12; cdb0_val = 32'hDEADBEEF;
            end
            tick(); idle();
            lit("wk_e1", 1'b0, 0, 0, 0);
            tick();
            lit("wk_e2", 1'b1, 32'hDEADBEEF, 32'd5, 5'd6);
        end

        // Allocation bypass, single CDB then both CDBs matching.
        issue(5'h02, 5'd8, 1'b0, 32'd11, 1'b1, 32'd4);
        cdb0_valid = 1'b1; cdb0_id = 5'd4; cdb0_val = 32'd100;
        tick(); idle();
        tick();
        lit("byp0", 1'b1, 32'd11, 32'd100, 5'd8);
        issue(5'h02, 5'd9, 1'b0, 32'd11, 1'b1, 32'd4);
        cdb0_valid = 1'b1; cdb0_id = 5'd4; cdb0_val = 32'd1;
        cdb1_valid = 1'b1; cdb1_id = 5'd4; cdb1_val = 32'd2;
        tick(); idle();
        tick();
        lit("byp_both", 1'b1, 32'd11, 32'd1, 5'd9);

        // Fill to eight entries waiting on tag 20.
        for (int i = 0; i < 8; i++) begin
            issue(5'h03, 5'(i), 1'b1, 32'd20, 1'b0, 32'(i));
            tick(); idle();
            chk("fill_full", {31'd0, rs_full}, {31'd0, (i >= 6)});
        end
        cdb1_valid = 1'b1; cdb1_id = 5'd20; cdb1_val = 32'hABC;
        tick(); idle();
        lit("fill_wake", 1'b0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            lit("fill_disp", 1'b1, 32'hABC, 32'(i), 5'(i));
            chk("fill_drain_full", {31'd0, rs_full}, {31'd0, (i == 0)});
        end
        tick();
        lit("fill_done", 1'b0, 0, 0, 0);

        // Stall: a ready op held while another wakes up.
        issue(5'h04, 5'd2, 1'b1, 32'd9, 1'b0, 32'h22);
        tick();
        issue(5'h05, 5'd1, 1'b0, 32'h33, 1'b0, 32'h44);
        tick(); idle();
        hci_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                cdb0_valid = 1'b1; cdb0_id = 5'd9; cdb0_val = 32'h99;
            end
            tick(); idle();
            lit("stall", 1'b0, 0, 0, 0);
        end
        hci_rdy = 1'b1;
        tick();
        lit("unstall0", 1'b1, 32'h99, 32'h22, 5'd2);
        tick();
        lit("unstall1", 1'b1, 32'h33, 32'h44, 5'd1);
        tick();
        lit("unstall_done", 1'b0, 0, 0, 0);

        // Flush four waiting entries plus a concurrent ready issue.
        for (int i = 0; i < 4; i++) begin
            issue(5'h06, 5'(10 + i), 1'b1, 32'd30, 1'b0, 32'd0);
            tick();
        end
        issue(5'h07, 5'd5, 1'b0, 32'd1, 1'b0, 32'd2);
        rob_rst = 1'b1;
        tick(); idle();
        chk("flush_full", {31'd0, rs_full}, 32'd0);
        cdb0_valid = 1'b1; cdb0_id = 5'd30; cdb0_val = 32'h77;
        tick(); idle();
        repeat (3) begin
            tick();
            lit("flush_quiet", 1'b0, 0, 0, 0);
        end

        // Asynchronous reset while exec_en is high.
        issue(5'h0A, 5'd7, 1'b0, 32'h1234, 1'b0, 32'h5678);
        tick(); idle();
        tick();
        lit("pre_arst", 1'b1, 32'h1234, 32'h5678, 5'd7);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_exec_en", {31'd0, exec_en}, 32'd0);
        chk("arst_exec_a", exec_a, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        issue(5'h0B, 5'd4, 1'b0, 32'h42, 1'b0, 32'h43);
        tick(); idle();
        lit("post_arst_e1", 1'b0, 0, 0, 0);
        tick();
        lit("post_arst_e2", 1'b1, 32'h42, 32'h43, 5'd4);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
